// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: per-channel state encoding and default parameters shared across the debouncer
package input_debouncer_pkg;
  typedef enum logic [1:0] {IDLE, FILTER, HELD, HOLD_DONE} state_t;
  localparam int DEF_CHANNELS = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES = 0;
  localparam bit DEF_ACTIVE_LOW = 1'b1;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/input_debouncer_if.sv
// input_debouncer_if: raw button levels and enable in, debounced state and event pulses out
interface input_debouncer_if import input_debouncer_pkg::*; #(parameter int CHANNELS = DEF_CHANNELS);
  logic en;
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_state;
  logic [CHANNELS-1:0] btn_press;
  logic [CHANNELS-1:0] btn_release;
  logic [CHANNELS-1:0] btn_hold;
  modport master(output en, btn_in, input btn_state, btn_press, btn_release, btn_hold);
  modport slave(input en, btn_in, output btn_state, btn_press, btn_release, btn_hold);
endinterface

// File: rtl/input_debouncer_debounce_chan.sv
// debounce_chan: one synchronised, filtered button channel with press/release/hold pulses
module debounce_chan import input_debouncer_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_in,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);
  localparam int W = $clog2(max2(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [W-1:0] D_LAST = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] H_MAX = W'(HOLD_CYCLES);
  logic [1:0] sync;
  state_t state, state_d, prev, prev_d;
  logic [W-1:0] cnt, cnt_d, hcnt, hcnt_d, hnext;
  logic lvl, s_d, press_d, release_d, hold_d;
  assign lvl = sync[1] ^ ACTIVE_LOW;
  assign hnext = (hcnt == H_MAX) ? hcnt : hcnt + W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= {2{ACTIVE_LOW}};
      state <= IDLE;
      prev <= IDLE;
      cnt <= '0;
      hcnt <= '0;
      btn_state <= 1'b0;
      btn_press <= 1'b0;
      btn_release <= 1'b0;
      btn_hold <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      state <= state_d;
      prev <= prev_d;
      cnt <= cnt_d;
      hcnt <= hcnt_d;
      btn_state <= s_d;
      btn_press <= press_d;
      btn_release <= release_d;
      btn_hold <= hold_d;
    end
  // FILTER remembers where it came from so a rejected glitch resumes hold counting untouched
  always_comb begin
    state_d = state;
    prev_d = prev;
    cnt_d = '0;
    hcnt_d = hcnt;
    s_d = btn_state;
    press_d = 1'b0;
    release_d = 1'b0;
    hold_d = 1'b0;
    if (!en) state_d = (state == FILTER) ? prev : state;
    else if (state == FILTER) begin
      if (lvl == btn_state) state_d = prev;
      else if (cnt == D_LAST) begin
        s_d = lvl;
        press_d = lvl;
        release_d = ~lvl;
        hcnt_d = '0;
        state_d = (lvl && HOLD_CYCLES > 0) ? HELD : IDLE;
      end else cnt_d = cnt + W'(1);
    end else if (lvl != btn_state) begin
      state_d = FILTER;
      prev_d = state;
      cnt_d = W'(1);
    end else if (state == HELD) begin
      hcnt_d = hnext;
      hold_d = (hnext == H_MAX);
      state_d = hold_d ? HOLD_DONE : HELD;
    end
  end
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: array of independent button debouncers behind a single interface
module input_debouncer import input_debouncer_pkg::*; #(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input logic clk,
  input logic rst,
  input_debouncer_if.slave bus
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .en(bus.en),
      .btn_in(bus.btn_in[i]),
      .btn_state(bus.btn_state[i]),
      .btn_press(bus.btn_press[i]),
      .btn_release(bus.btn_release[i]),
      .btn_hold(bus.btn_hold[i])
    );
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed scenarios for the 4-channel debouncer with hand-derived edge timing
module tb_input_debouncer;
  localparam int CH = 4;
  localparam int D = 4;
  localparam int H = 20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  input_debouncer_if #(.CHANNELS(CH)) bus();
  input_debouncer #(
    .CHANNELS(CH),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    bus.en = 1'b1;
    bus.btn_in = '1;
    tick(2);
    vectors++;
    if ({bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0000", {bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold});
    end
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      vectors++;
      if (bus.btn_state !== 4'h0 || bus.btn_press !== 4'h0) begin
        errors++;
        $display("FAIL idle_after_reset e=%0d state=%b press=%b want 0000 0000", e, bus.btn_state, bus.btn_press);
      end
    end
  endtask
  task automatic test_press_latency;
    logic [3:0] es, ep;
    bus.btn_in[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      es = (e >= 6) ? 4'b0001 : 4'b0000;
      ep = (e == 6) ? 4'b0001 : 4'b0000;
      vectors++;
      if (bus.btn_state !== es || bus.btn_press !== ep) begin
        errors++;
        $display("FAIL press_latency e=%0d state=%b press=%b want %b %b", e, bus.btn_state, bus.btn_press, es, ep);
      end
    end
    bus.btn_in[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      es = (e >= 6) ? 4'b0000 : 4'b0001;
      ep = (e == 6) ? 4'b0001 : 4'b0000;
      vectors++;
      if (bus.btn_state !== es || bus.btn_release !== ep || bus.btn_press !== 4'h0) begin
        errors++;
        $display("FAIL release_latency e=%0d state=%b release=%b press=%b want %b %b 0000", e, bus.btn_state, bus.btn_release, bus.btn_press, es, ep);
      end
    end
  endtask
  task automatic test_glitch;
    bus.btn_in[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) bus.btn_in[1] = 1'b1;
      tick(1);
      vectors++;
      if (bus.btn_state !== 4'h0 || bus.btn_press !== 4'h0 || bus.btn_release !== 4'h0) begin
        errors++;
        $display("FAIL glitch_reject e=%0d state=%b press=%b release=%b want 0000", e, bus.btn_state, bus.btn_press, bus.btn_release);
      end
    end
  endtask
  task automatic test_hold;
    logic [3:0] es, ep, eh, er;
    bus.btn_in[2] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 31) bus.btn_in[2] = 1'b1;
      tick(1);
      es = (e >= 6 && e < 36) ? 4'b0100 : 4'b0000;
      ep = (e == 6) ? 4'b0100 : 4'b0000;
      eh = (e == 26) ? 4'b0100 : 4'b0000;
      er = (e == 36) ? 4'b0100 : 4'b0000;
      vectors++;
      if (bus.btn_state !== es || bus.btn_press !== ep || bus.btn_hold !== eh || bus.btn_release !== er) begin
        errors++;
        $display("FAIL hold_seq e=%0d state=%b press=%b hold=%b release=%b want %b %b %b %b", e, bus.btn_state, bus.btn_press, bus.btn_hold, bus.btn_release, es, ep, eh, er);
      end
    end
  endtask
  task automatic test_simultaneous;
    logic [3:0] ex;
    bus.btn_in = 4'h0;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      ex = (e == 6) ? 4'hF : 4'h0;
      vectors++;
      if (bus.btn_press !== ex || bus.btn_hold !== 4'h0) begin
        errors++;
        $display("FAIL all_press e=%0d press=%b hold=%b want %b 0000", e, bus.btn_press, bus.btn_hold, ex);
      end
    end
    bus.btn_in = 4'hF;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      ex = (e == 6) ? 4'hF : 4'h0;
      vectors++;
      if (bus.btn_release !== ex || bus.btn_state !== ((e >= 6) ? 4'h0 : 4'hF)) begin
        errors++;
        $display("FAIL all_release e=%0d release=%b state=%b want %b", e, bus.btn_release, bus.btn_state, ex);
      end
    end
  endtask
  task automatic test_reset_mid;
    bus.btn_in[0] = 1'b0;
    tick(6);
    vectors++;
    if (bus.btn_state !== 4'b0001) begin
      errors++;
      $display("FAIL pre_reset_state got=%b want 0001", bus.btn_state);
    end
    bus.btn_in[3] = 1'b0;
    tick(4);
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h want 0000", {bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold});
    end
    bus.btn_in = '1;
    tick(3);
    rst = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      vectors++;
      if ({bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold} !== 16'h0) begin
        errors++;
        $display("FAIL post_reset_quiet e=%0d got=%h want 0000", e, {bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold});
      end
    end
  endtask
  task automatic test_enable;
    bus.en = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      bus.btn_in[0] = (e <= 10) ? 1'b0 : 1'b1;
      tick(1);
      vectors++;
      if ({bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold} !== 16'h0) begin
        errors++;
        $display("FAIL enable_frozen e=%0d got=%h want 0000", e, {bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_hold});
      end
    end
    bus.en = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      vectors++;
      if (bus.btn_state !== 4'h0 || bus.btn_press !== 4'h0) begin
        errors++;
        $display("FAIL reenable_quiet e=%0d state=%b press=%b want 0000 0000", e, bus.btn_state, bus.btn_press);
      end
    end
  endtask
  initial begin
    bus.en = 1'b1;
    bus.btn_in = '1;
    test_reset();
    test_press_latency();
    test_glitch();
    test_hold();
    test_simultaneous();
    test_reset_mid();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
